uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter, the transmit-side counterpart of the receive path in the UART_TOP subsystem. It accepts a parallel byte from the ALU/register-file side with a single-cycle valid strobe and serialises it onto `tx_out`. The frame is a start bit, LSB-first data, an optional even/odd parity bit and one stop bit. `clk` is the already-divided TX clock, so each frame bit lasts exactly one `clk` cycle.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame.
- `clk`, input, 1: TX bit clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `p_data`, input, `DATA_WIDTH`: parallel payload; sampled only on acceptance.
- `data_valid`, input, 1: request to send `p_data`; honoured only when idle.
- `par_en`, input, 1: 1 inserts a parity bit after the data bits; sampled on acceptance.
- `par_typ`, input, 1: 0 selects even parity, 1 selects odd; sampled on acceptance.
- `tx_out`, output, 1: serial line; idles high.
- `busy`, output, 1: high from the start bit through the stop bit.

## Operation
- States: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
- `IDLE`
  - `tx_out`=1, `busy`=0.
  - If `data_valid`=1, latch `p_data`, `par_en` and `par_typ` into internal registers and go to `START`.
- `START`: `tx_out`=0 for one cycle, then go to `DATA`. The bit counter is cleared.
- `DATA`
  - Drives `data_reg[bit_cnt]`, LSB first. `bit_cnt` counts 0..`DATA_WIDTH`-1.
  - At `bit_cnt`=`DATA_WIDTH`-1, go to `PARITY` if the latched `par_en`=1, otherwise go to `STOP`.
- `PARITY`
  - Drives the XOR-reduction of `data_reg` when `par_typ`=0 (even).
  - Drives its inverse when `par_typ`=1 (odd).
  - Lasts one cycle, then go to `STOP`.
- `STOP`: `tx_out`=1 for one cycle, then go to `IDLE` unconditionally.
- Acceptance:
  - Only in `IDLE`. `data_valid` in any other state is ignored, with no queuing and no error flag.
  - Changes on `p_data`, `par_en` or `par_typ` after acceptance have no effect on the frame in flight.
- Parity is computed from the latched `data_reg`, never from live `p_data`.

## Timing
- `tx_out` and `busy` are registered outputs; there are no combinational paths from inputs to outputs.
- Reset:
  - The state machine goes to `IDLE`, `tx_out`=1, `busy`=0, and `bit_cnt`, `data_reg` and the latched config are 0.
  - Reset takes effect immediately and asynchronously, including mid-frame; the partial frame is abandoned.
- Acceptance timing: with `data_valid`=1 in `IDLE` at edge E0:
  - After E0: `tx_out`=0 (start bit) and `busy`=1.
  - After E1..E8: data bits 0..7.
  - After E9: parity bit if enabled, otherwise stop bit.
- Frame length: `DATA_WIDTH`+2 = 10 cycles without parity, `DATA_WIDTH`+3 = 11 cycles with parity.
- End of frame: at the edge that ends the stop bit, the state becomes `IDLE`, `busy`=0 and `tx_out`=1. A `data_valid` sampled at that same edge is ignored, because the state was `STOP`.
- Back-to-back sends: the minimum frame period is frame length + 1 idle cycle, i.e. 11 cycles without parity and 12 with parity.

## Structure
- Shared package `uart_pkg`:
  - State encoding: 3-bit, `IDLE`=0.
  - Constants `START_BIT`=0, `STOP_BIT`=1, `IDLE_LINE`=1, `PAR_EVEN`=0, `PAR_ODD`=1.
  - Default `DATA_WIDTH`.
  - The RX side uses the same parity and bit constants.
- One sub-module, `uart_tx_parity_calc`:
  - Purely combinational.
  - Inputs: `data_reg` and `par_typ`. Output: the parity bit.
- The state machine, counter, data latch and output mux live in `uart_tx`.

## Test plan
- Reset release, then no stimulus for 20 cycles → `tx_out`=1 and `busy`=0 throughout.
- Send 0xA5 with `par_en`=0 → `tx_out` sequence 0,1,0,1,0,0,1,0,1,1, with `busy` high for exactly those 10 cycles.
- Send 0xA5 with `par_en`=1, `par_typ`=0 → parity bit 0. Send 0x07 with even parity → parity bit 1. Send 0x07 with odd parity → parity bit 0. Each frame is 11 cycles.
- Pulse `data_valid` with 0x3C during the data bits of a 0xFF frame, and change `p_data` mid-frame → the 0xFF frame is unaltered and no second frame follows.
- Hold `data_valid`=1 continuously with `par_en`=0 → frames repeat with exactly one idle `tx_out`=1 cycle between stop and start, giving an 11-cycle period.
- Assert `rst` low during data bit 4 → `tx_out`=1 and `busy`=0 immediately. After release, a new 0x5A frame transmits correctly from its start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame bit levels, parity selection and the
// transmitter state encoding. The receive side uses the same bit and
// parity constants, so both ends agree on the frame format.
package uart_pkg;

   // Payload width used by both directions unless a block overrides it
   localparam int DEFAULT_DATA_WIDTH = 8;

   // Line levels for the framing bits and the idle line
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_LINE = 1'b1;

   // Parity type selection as seen on par_typ
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Transmitter states; IDLE must stay at zero so reset lands there
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } txState_t;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity generator for the transmitter. Works on the latched payload so
// the parity bit always matches the data bits already on the line.
module uart_tx_parity_calc
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] data_reg,
   input  logic                  par_typ,
   output logic                  par_bit
);

   // Even parity is the XOR of all payload bits; odd parity is its inverse
   logic w_evenBit;

   assign w_evenBit = ^data_reg;
   assign par_bit   = (par_typ == PAR_ODD) ? ~w_evenBit : w_evenBit;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. Accepts a byte with a one-cycle valid strobe while
// idle and shifts out start bit, LSB-first data, optional parity and one
// stop bit, one bit per clk cycle. Both outputs come straight from flops.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   txState_t               r_state;
   logic [CNT_W-1:0]       r_bitCnt;
   logic [DATA_WIDTH-1:0]  r_dataReg;
   logic                   r_parEn;
   logic                   r_parTyp;
   logic                   r_txOut;
   logic                   r_busy;

   logic [CNT_W-1:0]       w_nextCnt;
   logic                   w_parBit;

   assign w_nextCnt = r_bitCnt + CNT_W'(1);

   uart_tx_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data_reg (r_dataReg),
      .par_typ  (r_parTyp),
      .par_bit  (w_parBit)
   );

   // Frame sequencer: the state names the bit currently on the line, and
   // each transition loads the level of the next bit into the output flop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_bitCnt  <= '0;
         r_dataReg <= '0;
         r_parEn   <= 1'b0;
         r_parTyp  <= 1'b0;
         r_txOut   <= IDLE_LINE;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (data_valid) begin
                  r_dataReg <= p_data;
                  r_parEn   <= par_en;
                  r_parTyp  <= par_typ;
                  r_state   <= START;
                  r_txOut   <= START_BIT;
                  r_busy    <= 1'b1;
               end else begin
                  r_txOut   <= IDLE_LINE;
                  r_busy    <= 1'b0;
               end
            end
            START: begin
               r_bitCnt <= '0;
               r_state  <= DATA;
               r_txOut  <= r_dataReg[0];
            end
            DATA: begin
               if (r_bitCnt == LAST_BIT) begin
                  if (r_parEn) begin
                     r_state <= PARITY;
                     r_txOut <= w_parBit;
                  end else begin
                     r_state <= STOP;
                     r_txOut <= STOP_BIT;
                  end
               end else begin
                  r_bitCnt <= w_nextCnt;
                  r_txOut  <= r_dataReg[w_nextCnt];
               end
            end
            PARITY: begin
               r_state <= STOP;
               r_txOut <= STOP_BIT;
            end
            STOP: begin
               r_state <= IDLE;
               r_txOut <= IDLE_LINE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_txOut <= IDLE_LINE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_out = r_txOut;
   assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A frame-level model turns every
// accepted request into a queue of expected line bits; a compare process
// checks tx_out and busy against it on every falling edge, and directed
// scenarios pin hand-computed frames.
module tb_uart_tx;

   logic       clk;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic       tx_out;
   logic       busy;

   int passCount  = 0;
   int totalCount = 0;
   bit cmpEn      = 1'b0;

   logic expTx   = 1'b1;
   logic expBusy = 1'b0;
   logic expQ[$];

   logic [15:0] txBits;
   logic [15:0] busyBits;

   uart_tx #(
      .DATA_WIDTH (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .tx_out     (tx_out),
      .busy       (busy)
   );

   // Free-running bit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point shared by every check in the bench
   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      totalCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
   endtask

   // Frame-level reference: an accepted request becomes the list of bits
   // the line must show; the edge after the last bit returns to idle
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            expQ.delete();
            expTx   = 1'b1;
            expBusy = 1'b0;
         end else if (expQ.size() > 0) begin
            expTx   = expQ.pop_front();
            expBusy = 1'b1;
         end else if (expBusy) begin
            expTx   = 1'b1;
            expBusy = 1'b0;
         end else if (data_valid) begin
            expTx   = 1'b0;
            expBusy = 1'b1;
            for (int b = 0; b < 8; b++) expQ.push_back(p_data[b]);
            if (par_en) expQ.push_back(logic'($countones(p_data) % 2) ^ par_typ);
            expQ.push_back(1'b1);
         end else begin
            expTx   = 1'b1;
            expBusy = 1'b0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model while out of reset
   always @(negedge clk) begin
      if (rst && cmpEn) begin
         checkOutput("model tx_out", 16'(tx_out), 16'(expTx));
         checkOutput("model busy", 16'(busy), 16'(expBusy));
      end
   end

   // Present one request on the next falling edge
   task automatic applyStimulus(input logic [7:0] data, input logic pe, input logic pt);
      @(negedge clk);
      p_data     = data;
      par_en     = pe;
      par_typ    = pt;
      data_valid = 1'b1;
   endtask

   // Record n line samples after a request; the inputs are scrambled once
   // accepted, and an optional stray request is injected mid-frame
   task automatic captureFrame(input int n, input int glitchAt,
                               output logic [15:0] txCap, output logic [15:0] busyCap);
      txCap   = '0;
      busyCap = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) begin
            data_valid = 1'b0;
            p_data     = 8'($urandom);
            par_en     = ~par_en;
            par_typ    = ~par_typ;
         end
         if (i == glitchAt) begin
            data_valid = 1'b1;
            p_data     = 8'h3C;
            par_en     = 1'b1;
         end
         if (i == glitchAt + 1) begin
            data_valid = 1'b0;
            p_data     = 8'h00;
         end
         txCap[i]   = tx_out;
         busyCap[i] = busy;
      end
   endtask

   // Bounded wait for the line to go idle
   task automatic waitIdle();
      int cycles;
      cycles = 0;
      while (busy && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      if (busy) checkOutput("idle timeout busy", 16'(busy), 16'd0);
   endtask

   // Parity frame: 11 busy cycles, parity bit at slot 9, stop at slot 10
   task automatic parityFrame(input logic [7:0] data, input logic pt, input logic expPar, input string tag);
      applyStimulus(data, 1'b1, pt);
      captureFrame(12, -1, txBits, busyBits);
      checkOutput({tag, " parity bit"}, 16'(txBits[9]), 16'(expPar));
      checkOutput({tag, " stop bit"}, 16'(txBits[10]), 16'd1);
      checkOutput({tag, " start bit"}, 16'(txBits[0]), 16'd0);
      checkOutput({tag, " busy span"}, busyBits & 16'h0FFF, 16'h07FF);
   endtask

   initial begin
      rst        = 1'b0;
      p_data     = 8'h00;
      data_valid = 1'b0;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      repeat (3) @(negedge clk);
      rst   = 1'b1;
      cmpEn = 1'b1;

      // Quiet line after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("reset idle tx_out", 16'(tx_out), 16'd1);
         checkOutput("reset idle busy", 16'(busy), 16'd0);
      end

      // 0xA5 without parity
      applyStimulus(8'hA5, 1'b0, 1'b0);
      captureFrame(11, -1, txBits, busyBits);
      checkOutput("A5 frame bits", txBits & 16'h03FF, 16'h034A);
      checkOutput("A5 busy span", busyBits & 16'h07FF, 16'h03FF);
      checkOutput("A5 idle after", 16'(txBits[10]), 16'd1);

      // Parity frames
      parityFrame(8'hA5, 1'b0, 1'b0, "A5 even");
      parityFrame(8'h07, 1'b0, 1'b1, "07 even");
      parityFrame(8'h07, 1'b1, 1'b0, "07 odd");

      // 0xFF with a stray request during the data bits
      applyStimulus(8'hFF, 1'b0, 1'b0);
      captureFrame(16, 3, txBits, busyBits);
      checkOutput("FF frame bits", txBits & 16'h03FF, 16'h03FE);
      checkOutput("FF busy span", busyBits, 16'h03FF);
      checkOutput("FF no second frame", txBits & 16'hFC00, 16'hFC00);

      // Continuous request: 11-cycle frame period
      @(negedge clk);
      p_data     = 8'h81;
      par_en     = 1'b0;
      data_valid = 1'b1;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i < 16) begin
            txBits[i]   = tx_out;
            busyBits[i] = busy;
         end
         if (i == 11) checkOutput("b2b second start", 16'(tx_out), 16'd0);
         if (i == 22) checkOutput("b2b third start", 16'(tx_out), 16'd0);
      end
      checkOutput("b2b idle gap tx", 16'(txBits[10]), 16'd1);
      checkOutput("b2b idle gap busy", 16'(busyBits[10]), 16'd0);
      checkOutput("b2b first frame", txBits & 16'h03FF, 16'h0302);
      data_valid = 1'b0;
      waitIdle();

      // Reset during data bit 4
      applyStimulus(8'hC3, 1'b1, 1'b0);
      captureFrame(6, -1, txBits, busyBits);
      checkOutput("pre-reset busy", 16'(busyBits[5]), 16'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("async reset tx_out", 16'(tx_out), 16'd1);
      checkOutput("async reset busy", 16'(busy), 16'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      applyStimulus(8'h5A, 1'b0, 1'b0);
      captureFrame(11, -1, txBits, busyBits);
      checkOutput("5A frame bits", txBits & 16'h03FF, 16'h02B4);
      checkOutput("5A busy span", busyBits & 16'h07FF, 16'h03FF);

      // Random requests against the model
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         p_data     = 8'($urandom);
         par_en     = 1'($urandom);
         par_typ    = 1'($urandom);
         data_valid = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      data_valid = 1'b0;
      waitIdle();
      repeat (2) @(negedge clk);

      cmpEn = 1'b0;
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
